regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (rd_address/rd_value/reg_write) between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load/LSU writeback).
- Arbitration: round-robin with a valid/ready handshake.
- Output: one registered write stage drives the RegisterFile write port.
- Forwarding: the pending write in that stage is bypassed onto both read ports, so same-cycle readers never see stale data.
- Placement: between the writeback stage and the RegisterFile, alongside the forwarding logic.

Parameters:
ADDR_W, 5, register address width (32 registers; address 0 is hardwired zero)
DATA_W, 32, register data width
CNT_W, 16, width of the per-requester stall counters

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req0_valid  input  1  ALU write request valid
req0_addr  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU write data
req0_ready  output  1  ALU request accepted this cycle
req1_valid  input  1  LSU write request valid
req1_addr  input  ADDR_W  LSU destination register
req1_data  input  DATA_W  LSU write data
req1_ready  output  1  LSU request accepted this cycle
rd_address  output  ADDR_W  to RegisterFile write address
rd_value  output  DATA_W  to RegisterFile write data
reg_write  output  1  to RegisterFile write enable
rs_address  input  ADDR_W  read port A address (also drives RegisterFile)
rt_address  input  ADDR_W  read port B address
rs_rf_value  input  DATA_W  RegisterFile rs_value
rt_rf_value  input  DATA_W  RegisterFile rt_value
rs_value  output  DATA_W  forwarded read data A
rt_value  output  DATA_W  forwarded read data B
stall_cnt0  output  CNT_W  cycles req0 valid but not ready, saturating
stall_cnt1  output  CNT_W  cycles req1 valid but not ready, saturating

Behaviour:
- Handshake: transfer occurs when valid & ready at a rising edge. A requester holds valid/addr/data stable until ready. Ready may depend combinationally on both valids; valid must never depend on ready.
- Grant, combinational:
  - Only one valid: that requester is ready.
  - Both valid: the requester not granted last time is ready.
  - Neither valid: both ready low.
  - At most one ready is high per cycle.
- last_grant register: updates to the granted index on every transfer. Reset value 1, so req0 wins the first contest.
- Write stage registers (rd_address, rd_value, reg_write):
  - Loaded at the edge where a transfer occurs.
  - reg_write = 1 only if the granted addr != 0. Writes to address 0 are accepted, consume the grant slot and are dropped (reg_write = 0, rd_address/rd_value still loaded).
  - No transfer: reg_write = 0; rd_address/rd_value hold.
- Latency: transfer at edge N -> reg_write high during cycle N..N+1 -> RegisterFile commits at edge N+1. Throughput is one write per cycle.
- Forwarding, combinational: rs_value = rd_value if reg_write & rd_address == rs_address, else rs_rf_value. rt_value uses the same rule with rt_address.
- Address 0 never forwards, because reg_write is never set for address 0.
- Stall counters: increment when reqX_valid & !reqX_ready and the counter is below 2^CNT_W-1; saturate at all-ones; never decrement.
- Same destination from both requesters: no merging. Writes reach the port in grant order, so the later-granted value wins in the RegisterFile.
- Reset (rst_n low at an edge):
  - Register state: reg_write = 0, rd_address = 0, rd_value = 0, last_grant = 1, stall counters = 0.
  - While rst_n is low, req0_ready = req1_ready = 0 and no transfer occurs.
  - Reset mid-operation discards any pending stage write.
  - First contest after release goes to req0.

Decomposition:
- Shared package: ADDR_W/DATA_W constants, REG_ZERO = 0, requester index constants REQ_ALU = 0 and REQ_LSU = 1.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with last_grant register).
- The write stage, forwarding muxes and counters stay in the top.

Test Plan:
1. Single write: req0 (addr 1, data 5) for one cycle -> req0_ready=1. Next cycle reg_write=1, rd_address=1, rd_value=5. The cycle after, rs_address=1 reads 5 from the RegisterFile.
2. Both valid from reset: req0 (3, 0xA) and req1 (4, 0xB) held until accepted -> req0 granted first, req1 next cycle. Port shows (3,0xA) then (4,0xB); stall_cnt1=1, stall_cnt0=0.
3. Both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 and reg_write stays high every cycle after the first.
4. Zero-address write: req1 (0, 0xFFFF) -> req1_ready=1, reg_write stays 0, rs_address=0 gives rs_value=rs_rf_value.
5. Bypass: stage holds write (31, 7) and rt_address=31 with rt_rf_value=0 -> rt_value=7 that cycle. With rt_address=30, rt_value=rt_rf_value.
6. Reset mid-operation: rst_n=0 while reg_write=1 and both requesters valid -> next edge reg_write=0, counters 0, readys low during reset. After release with both valid, req0 wins first.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and grant helper for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 16;

  // Register 0 is hardwired to zero; writes to it are accepted and dropped.
  localparam int unsigned REG_ZERO = 0;

  // Requester indices.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // Two-way round-robin pick: on a contest the requester not granted last time wins.
  function automatic logic pick_grant(input logic [1:0] valid, input logic last);
    logic pick;
    if (valid == 2'b11) begin
      pick = ~last;
    end else begin
      pick = valid[1];
    end
    return pick;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with valid/ready handshake and last-grant memory.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  output logic [1:0] ready_o,
  output logic       grant_o
);

  logic last_q, last_d;
  logic pick;

  // Grant decode; readys are held low while in reset so nothing transfers.
  always_comb begin
    pick    = pick_grant(valid_i, last_q);
    ready_o = 2'b00;
    if (rst_ni && (valid_i != 2'b00)) begin
      ready_o = pick ? 2'b10 : 2'b01;
    end
    grant_o = pick;
    last_d  = (ready_o != 2'b00) ? pick : last_q;
  end

  // Last-grant register; resets to the LSU so the ALU wins the first contest.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback, with a
// registered write stage that is bypassed onto both read ports.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W = regfile_write_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W = regfile_write_arbiter_pkg::DATA_W,
  parameter int unsigned CNT_W  = regfile_write_arbiter_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] rd_value,
  output logic              reg_write,
  input  logic [ADDR_W-1:0] rs_address,
  input  logic [ADDR_W-1:0] rt_address,
  input  logic [DATA_W-1:0] rs_rf_value,
  input  logic [DATA_W-1:0] rt_rf_value,
  output logic [DATA_W-1:0] rs_value,
  output logic [DATA_W-1:0] rt_value,
  output logic [CNT_W-1:0]  stall_cnt0,
  output logic [CNT_W-1:0]  stall_cnt1
);

  import regfile_write_arbiter_pkg::*;

  logic [1:0]        valid;
  logic [1:0]        ready;
  logic              grant;
  logic              xfer;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  logic              reg_write_q;
  logic [ADDR_W-1:0] rd_address_q;
  logic [DATA_W-1:0] rd_value_q;
  logic [CNT_W-1:0]  stall0_q, stall0_d;
  logic [CNT_W-1:0]  stall1_q, stall1_d;

  assign valid = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid),
    .ready_o (ready),
    .grant_o (grant)
  );

  assign req0_ready = ready[REQ_ALU];
  assign req1_ready = ready[REQ_LSU];
  assign xfer       = |ready;

  // Select the granted request's payload.
  always_comb begin
    gnt_addr = req0_addr;
    gnt_data = req0_data;
    if (grant == REQ_LSU) begin
      gnt_addr = req1_addr;
      gnt_data = req1_data;
    end
  end

  // Write stage: load on transfer; address 0 consumes the slot but never writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      rd_address_q <= '0;
      rd_value_q   <= '0;
    end else begin
      reg_write_q <= xfer && (gnt_addr != ADDR_W'(REG_ZERO));
      if (xfer) begin
        rd_address_q <= gnt_addr;
        rd_value_q   <= gnt_data;
      end
    end
  end

  assign reg_write  = reg_write_q;
  assign rd_address = rd_address_q;
  assign rd_value   = rd_value_q;

  // Bypass the pending stage write onto both read ports.
  always_comb begin
    rs_value = rs_rf_value;
    rt_value = rt_rf_value;
    if (reg_write_q && (rd_address_q == rs_address)) begin
      rs_value = rd_value_q;
    end
    if (reg_write_q && (rd_address_q == rt_address)) begin
      rt_value = rd_value_q;
    end
  end

  // Saturating stall counters: count cycles a requester waits.
  always_comb begin
    stall0_d = stall0_q;
    stall1_d = stall1_q;
    if (req0_valid && !req0_ready && (stall0_q != {CNT_W{1'b1}})) begin
      stall0_d = stall0_q + CNT_W'(1);
    end
    if (req1_valid && !req1_ready && (stall1_q != {CNT_W{1'b1}})) begin
      stall1_d = stall1_q + CNT_W'(1);
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end

  assign stall_cnt0 = stall0_q;
  assign stall_cnt1 = stall1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table plus a scoreboard of expected
// write-stage contents, with a small RegisterFile model behind the port.
module tb_regfile_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;  // narrow counters so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_value;
  logic          reg_write;
  logic [AW-1:0] rs_address, rt_address;
  logic [DW-1:0] rs_rf_value, rt_rf_value;
  logic [DW-1:0] rs_value, rt_value;
  logic [CW-1:0] stall_cnt0, stall_cnt1;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .rd_address  (rd_address),
    .rd_value    (rd_value),
    .reg_write   (reg_write),
    .rs_address  (rs_address),
    .rt_address  (rt_address),
    .rs_rf_value (rs_rf_value),
    .rt_rf_value (rt_rf_value),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .stall_cnt0  (stall_cnt0),
    .stall_cnt1  (stall_cnt1)
  );

  // RegisterFile behind the write port (register 0 reads as zero).
  logic [DW-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) begin
    if (reg_write === 1'b1 && rd_address != '0) rf[rd_address] <= rd_value;
  end
  assign rs_rf_value = rf[rs_address];
  assign rt_rf_value = rf[rt_address];

  typedef struct {
    logic          rst_n;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          er0;
    logic          er1;
  } vec_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } stg_t;

  int   errors = 0;
  int   checks = 0;
  stg_t sbq[$];
  vec_t tbl[22];

  // Reference model state.
  logic          m_last;
  logic [CW-1:0] m_st0, m_st1;
  logic [DW-1:0] arch [32];
  stg_t          m_stg;

  function automatic vec_t mk(input logic r, input logic v0, input int a0, input int d0,
                              input logic v1, input int a1, input int d1,
                              input int rs, input int rt, input logic er0, input logic er1);
    vec_t v;
    v.rst_n = r;
    v.v0 = v0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.v1 = v1; v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.rs = AW'(rs); v.rt = AW'(rt);
    v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, clock,
  // then compare the registered stage against the scoreboard.
  task automatic run_cycle(input vec_t v);
    logic          g0, g1;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    stg_t          e;
    rst_n = v.rst_n;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    rs_address = v.rs; rt_address = v.rt;
    #1;
    chk("req0_ready", DW'(req0_ready), DW'(v.er0));
    chk("req1_ready", DW'(req1_ready), DW'(v.er1));
    chk("rs_value", rs_value, arch[v.rs]);
    chk("rt_value", rt_value, arch[v.rt]);
    if (!v.rst_n) begin
      m_last = 1'b1;
      m_st0  = '0;
      m_st1  = '0;
      m_stg  = '0;
    end else begin
      g0 = v.v0 && (!v.v1 || m_last);
      g1 = v.v1 && !g0;
      if (v.v0 && !g0 && m_st0 != '1) m_st0 = m_st0 + 1'b1;
      if (v.v1 && !g1 && m_st1 != '1) m_st1 = m_st1 + 1'b1;
      if (g0 || g1) begin
        a = g1 ? v.a1 : v.a0;
        d = g1 ? v.d1 : v.d0;
        m_stg = {(a != '0), a, d};
        if (a != '0) arch[a] = d;
        m_last = g1;
      end else begin
        m_stg.we = 1'b0;
      end
    end
    sbq.push_back(m_stg);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("reg_write", DW'(reg_write), DW'(e.we));
    chk("rd_address", DW'(rd_address), DW'(e.a));
    chk("rd_value", rd_value, e.d);
    chk("stall_cnt0", DW'(stall_cnt0), DW'(m_st0));
    chk("stall_cnt1", DW'(stall_cnt1), DW'(m_st1));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) arch[i] = '0;
    m_last = 1'b1; m_st0 = '0; m_st1 = '0; m_stg = '0;

    //            rst v0 a0  d0      v1 a1  d1       rs  rt  r0 r1
    tbl[0]  = mk(0,  1, 3,  'hA,    1, 4,  'hB,     0,  0,  0, 0);
    tbl[1]  = mk(1,  1, 1,  5,      0, 0,  0,       0,  0,  1, 0);
    tbl[2]  = mk(1,  0, 0,  0,      0, 0,  0,       1,  0,  0, 0);
    tbl[3]  = mk(1,  0, 0,  0,      0, 0,  0,       1,  0,  0, 0);
    tbl[4]  = mk(0,  0, 0,  0,      0, 0,  0,       1,  0,  0, 0);
    tbl[5]  = mk(1,  1, 3,  'hA,    1, 4,  'hB,     3,  4,  1, 0);
    tbl[6]  = mk(1,  0, 0,  0,      1, 4,  'hB,     3,  4,  0, 1);
    tbl[7]  = mk(1,  1, 5,  'h50,   1, 6,  'h60,    3,  4,  1, 0);
    tbl[8]  = mk(1,  1, 7,  'h70,   1, 6,  'h60,    5,  6,  0, 1);
    tbl[9]  = mk(1,  1, 7,  'h70,   1, 8,  'h80,    5,  6,  1, 0);
    tbl[10] = mk(1,  1, 9,  'h90,   1, 8,  'h80,    7,  8,  0, 1);
    tbl[11] = mk(1,  1, 9,  'h90,   1, 10, 'hA0,    7,  8,  1, 0);
    tbl[12] = mk(1,  1, 11, 'hB0,   1, 10, 'hA0,    9,  10, 0, 1);
    tbl[13] = mk(1,  0, 0,  0,      1, 0,  'hFFFF,  11, 10, 0, 1);
    tbl[14] = mk(1,  0, 0,  0,      0, 0,  0,       0,  0,  0, 0);
    tbl[15] = mk(1,  1, 31, 7,      0, 0,  0,       0,  31, 1, 0);
    tbl[16] = mk(1,  0, 0,  0,      0, 0,  0,       30, 31, 0, 0);
    tbl[17] = mk(1,  1, 2,  'h22,   1, 9,  'h99,    30, 30, 0, 1);
    tbl[18] = mk(0,  1, 2,  'h22,   1, 9,  'h99,    9,  31, 0, 0);
    tbl[19] = mk(1,  1, 2,  'h22,   1, 9,  'h99,    9,  2,  1, 0);
    tbl[20] = mk(1,  0, 0,  0,      1, 9,  'h99,    2,  9,  0, 1);
    tbl[21] = mk(1,  0, 0,  0,      0, 0,  0,       2,  9,  0, 0);

    // Bring-up reset with idle requesters.
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rs_address = '0; rt_address = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset reg_write", DW'(reg_write), '0);
    chk("reset rd_address", DW'(rd_address), '0);
    chk("reset rd_value", rd_value, '0);
    chk("reset stall_cnt0", DW'(stall_cnt0), '0);
    chk("reset stall_cnt1", DW'(stall_cnt1), '0);

    for (int i = 0; i < 22; i++) run_cycle(tbl[i]);

    // Continuous contention from reset: grants alternate and both counters saturate.
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      run_cycle(mk(1, 1, 12, 'h1000 + (i + 1) / 2, 1, 20, 'h2000 + i / 2,
                   12, 20, (i % 2) == 0, (i % 2) == 1));
    end
    chk("stall_cnt0 saturated", DW'(stall_cnt0), DW'(3'h7));
    chk("stall_cnt1 saturated", DW'(stall_cnt1), DW'(3'h7));
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 12, 20, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
